// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sprite path.
// Holds screen-size defaults, coordinate widths, RGB332 field positions and
// helpers, the per-rectangle state record, the motion FSM state type, and
// the power-on layout of each rectangle.
package vga_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    // Coverage compares are done one bit wider than X_W so x+width cannot wrap.
    localparam int COORD_W     = 11;
    // Velocities are kept sign-extended to this width inside rect_t.
    localparam int VEL_STORE_W = 8;

    // RGB332 layout {R[2:0],G[2:0],B[1:0]}
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef struct packed {
        logic        [X_W-1:0]         x;
        logic        [Y_W-1:0]         y;
        logic signed [VEL_STORE_W-1:0] dx;
        logic signed [VEL_STORE_W-1:0] dy;
        logic        [7:0]             color;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } motion_state_t;

    function automatic logic [2:0] rgb_r(input logic [7:0] c);
        return c[R_HI:R_LO];
    endfunction

    function automatic logic [2:0] rgb_g(input logic [7:0] c);
        return c[G_HI:G_LO];
    endfunction

    function automatic logic [1:0] rgb_b(input logic [7:0] c);
        return c[B_HI:B_LO];
    endfunction

    // Diagonal staircase layout; wraps if it would leave the screen.
    function automatic rect_t reset_rect(input int k, input int h_res, input int v_res);
        rect_t r;
        r.x  = X_W'((120 + 80 * k) % h_res);
        r.y  = Y_W'((40 + 80 * k) % v_res);
        r.dx = 8'sd1;
        r.dy = 8'sd1;
        case (k)
            0:       r.color = 8'h1C;
            1:       r.color = 8'hE0;
            2:       r.color = 8'h03;
            3:       r.color = 8'h1C;
            default: r.color = 8'hFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rect_bounce_axis.sv
// Single-axis bounce step (combinational).
// Ports:
//   pos      current position on this axis
//   vel      current signed velocity (sign-extended)
//   next_pos position after one frame step, clamped to [0, LIMIT]
//   next_vel velocity after the step, negated on an edge hit
module rect_bounce_axis
    import vga_pkg::*;
#(
    parameter int POS_W = 10,
    parameter int LIMIT = 480
) (
    input  logic        [POS_W-1:0]       pos,
    input  logic signed [VEL_STORE_W-1:0] vel,
    output logic        [POS_W-1:0]       next_pos,
    output logic signed [VEL_STORE_W-1:0] next_vel
);

    logic [VEL_STORE_W-1:0] mag;
    logic [15:0]            pos_e;
    logic [15:0]            mag_e;
    logic                   neg;
    logic                   nonzero;

    assign neg     = vel[VEL_STORE_W-1];
    assign nonzero = (vel != '0);
    assign mag     = neg ? VEL_STORE_W'(-vel) : VEL_STORE_W'(vel);
    assign pos_e   = 16'(pos);
    assign mag_e   = 16'(mag);

    always_comb begin
        next_pos = pos;
        next_vel = vel;
        if (neg) begin
            if (pos_e < mag_e) begin
                next_pos = '0;
                next_vel = -vel;
            end else begin
                next_pos = POS_W'(pos_e - mag_e);
            end
        end else if (nonzero) begin
            if ((pos_e + mag_e) > 16'(LIMIT)) begin
                next_pos = POS_W'(LIMIT);
                next_vel = -vel;
            end else begin
                next_pos = POS_W'(pos_e + mag_e);
            end
        end
    end

endmodule

// File: rtl/rect_sprite_engine.sv
// Bouncing-rectangle sprite engine between the VGA timing block and the pins.
// Ports:
//   i_clk, i_rst_n         system clock, async active-low reset
//   i_pix_stb              pixel enable; output registers load only on it
//   i_x, i_y, i_active     current pixel position and active-video flag
//   i_frame, i_pause       end-of-frame pulse, motion freeze
//   i_wr_*                 one-clock config write of a whole rectangle
//   o_r, o_g, o_b          composited RGB332 colour (one strobe latency)
//   o_hit                  per-rectangle coverage of the displayed pixel
//   o_busy                 motion update in progress
//
// Motion FSM
//   state     | meaning
//   ST_IDLE   | waiting for an unpaused frame pulse
//   ST_UPDATE | stepping rectangle idx, one per clock
//   ST_DONE   | single trailing busy clock before returning to idle
module rect_sprite_engine
    import vga_pkg::*;
#(
    parameter int N_RECT = 4,
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int RECT_W = 160,
    parameter int RECT_H = 160,
    parameter int VEL_W  = 4,
    localparam int IDX_W = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    input  logic              i_active,
    input  logic              i_frame,
    input  logic              i_pause,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [X_W-1:0]    i_wr_x,
    input  logic [Y_W-1:0]    i_wr_y,
    input  logic [VEL_W-1:0]  i_wr_dx,
    input  logic [VEL_W-1:0]  i_wr_dy,
    input  logic [7:0]        i_wr_color,
    output logic [2:0]        o_r,
    output logic [2:0]        o_g,
    output logic [1:0]        o_b,
    output logic [N_RECT-1:0] o_hit,
    output logic              o_busy
);

    motion_state_t          state;
    logic [IDX_W-1:0]       idx;
    rect_t                  rects [N_RECT];
    rect_t                  cur;
    rect_t                  stepped;
    rect_t                  wr_rect;
    logic [X_W-1:0]         nx;
    logic [Y_W-1:0]         ny;
    logic signed [VEL_STORE_W-1:0] ndx;
    logic signed [VEL_STORE_W-1:0] ndy;
    logic [N_RECT-1:0]      hit;
    logic [7:0]             pix_color;

    // Sign-extend a loaded velocity; the most-negative code is pulled in by
    // one so that negating it on a bounce can never overflow.
    function automatic logic signed [VEL_STORE_W-1:0] load_vel(input logic [VEL_W-1:0] v);
        logic signed [VEL_STORE_W-1:0] ext;
        ext = {{(VEL_STORE_W - VEL_W){v[VEL_W-1]}}, v};
        if (v == {1'b1, {(VEL_W - 1){1'b0}}}) begin
            ext = ext + 8'sd1;
        end
        return ext;
    endfunction

    function automatic logic covers(input logic [COORD_W-1:0] coord,
                                    input logic [COORD_W-1:0] edge_lo,
                                    input logic [COORD_W-1:0] extent);
        return (coord > edge_lo) && (coord < (edge_lo + extent));
    endfunction

    assign cur = rects[idx];

    rect_bounce_axis #(
        .POS_W (X_W),
        .LIMIT (H_RES - RECT_W)
    ) u_axis_x (
        .pos      (cur.x),
        .vel      (cur.dx),
        .next_pos (nx),
        .next_vel (ndx)
    );

    rect_bounce_axis #(
        .POS_W (Y_W),
        .LIMIT (V_RES - RECT_H)
    ) u_axis_y (
        .pos      (cur.y),
        .vel      (cur.dy),
        .next_pos (ny),
        .next_vel (ndy)
    );

    always_comb begin
        stepped       = cur;
        stepped.x     = nx;
        stepped.y     = ny;
        stepped.dx    = ndx;
        stepped.dy    = ndy;
        wr_rect.x     = i_wr_x;
        wr_rect.y     = i_wr_y;
        wr_rect.dx    = load_vel(i_wr_dx);
        wr_rect.dy    = load_vel(i_wr_dy);
        wr_rect.color = i_wr_color;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_frame && !i_pause) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (idx == IDX_W'(N_RECT - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A config write to the rectangle being stepped in the same clock wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_RECT; k++) begin
                rects[k] <= reset_rect(k, H_RES, V_RES);
            end
        end else begin
            for (int k = 0; k < N_RECT; k++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    rects[k] <= wr_rect;
                end else if ((state == ST_UPDATE) && (idx == IDX_W'(k))) begin
                    rects[k] <= stepped;
                end
            end
        end
    end

    // Walk from the lowest priority upward so index 0 overwrites last.
    always_comb begin
        hit       = '0;
        pix_color = 8'h00;
        for (int k = N_RECT - 1; k >= 0; k--) begin
            if (covers(COORD_W'(i_x), COORD_W'(rects[k].x), COORD_W'(RECT_W)) &&
                covers(COORD_W'(i_y), COORD_W'(rects[k].y), COORD_W'(RECT_H))) begin
                hit[k]    = 1'b1;
                pix_color = rects[k].color;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r   <= '0;
            o_g   <= '0;
            o_b   <= '0;
            o_hit <= '0;
        end else if (i_pix_stb) begin
            if (i_active) begin
                o_r   <= rgb_r(pix_color);
                o_g   <= rgb_g(pix_color);
                o_b   <= rgb_b(pix_color);
                o_hit <= hit;
            end else begin
                o_r   <= '0;
                o_g   <= '0;
                o_b   <= '0;
                o_hit <= '0;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rect_sprite_engine.sv
// Testbench for rect_sprite_engine: directed stimulus, a spec-level model of
// the rectangle set, a per-cycle output compare, and literal pixel probes.
module tb_rect_sprite_engine;

    localparam int N  = 4;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int RW = 160;
    localparam int RH = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_stb = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       active = 1'b0;
    logic       frame = 1'b0;
    logic       pause = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [9:0] wr_x = '0;
    logic [8:0] wr_y = '0;
    logic [3:0] wr_dx = '0;
    logic [3:0] wr_dy = '0;
    logic [7:0] wr_color = '0;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic [3:0] hit;
    logic       busy;

    rect_sprite_engine dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pix_stb  (pix_stb),
        .i_x        (x),
        .i_y        (y),
        .i_active   (active),
        .i_frame    (frame),
        .i_pause    (pause),
        .i_wr_en    (wr_en),
        .i_wr_idx   (wr_idx),
        .i_wr_x     (wr_x),
        .i_wr_y     (wr_y),
        .i_wr_dx    (wr_dx),
        .i_wr_dy    (wr_dy),
        .i_wr_color (wr_color),
        .o_r        (r),
        .o_g        (g),
        .o_b        (b),
        .o_hit      (hit),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int mx [N];
    int my [N];
    int mdx [N];
    int mdy [N];
    int mcol [N];
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_col = '0;
    logic [3:0] exp_hit = '0;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k]  = (120 + 80 * k) % H;
            my[k]  = (40 + 80 * k) % V;
            mdx[k] = 1;
            mdy[k] = 1;
            mcol[k] = (k == 0) ? 8'h1C : (k == 1) ? 8'hE0 : (k == 2) ? 8'h03 :
                      (k == 3) ? 8'h1C : 8'hFF;
        end
    endtask

    function automatic void axis_step(input int p, input int v, input int lim,
                                      output int np, output int nv);
        np = p;
        nv = v;
        if (v < 0 && p < -v) begin
            np = 0;
            nv = -v;
        end else if (v > 0 && p + v > lim) begin
            np = lim;
            nv = -v;
        end else begin
            np = p + v;
        end
    endfunction

    task automatic model_frame();
        int a, c;
        for (int k = 0; k < N; k++) begin
            axis_step(mx[k], mdx[k], H - RW, a, c);
            mx[k] = a;
            mdx[k] = c;
            axis_step(my[k], mdy[k], V - RH, a, c);
            my[k] = a;
            mdy[k] = c;
        end
    endtask

    function automatic int vel_of(input int raw);
        int s;
        s = (raw >= 8) ? raw - 16 : raw;
        if (s == -8) s = -7;
        return s;
    endfunction

    task automatic model_write(input int k, input int px, input int py,
                               input int dxr, input int dyr, input int c);
        mx[k]  = px;
        my[k]  = py;
        mdx[k] = vel_of(dxr);
        mdy[k] = vel_of(dyr);
        mcol[k] = c;
    endtask

    function automatic void model_pixel(input int px, input int py, input bit act,
                                        output logic [7:0] c, output logic [3:0] h);
        c = 8'h00;
        h = 4'h0;
        if (act) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (px > mx[k] && px < mx[k] + RW && py > my[k] && py < my[k] + RH) begin
                    h[k] = 1'b1;
                    c = 8'(mcol[k]);
                end
            end
        end
    endfunction

    // Per-cycle compare: outputs must always equal the model's view of the
    // last pixel strobed in.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_col = 8'h00;
            exp_hit = 4'h0;
        end else if (pix_stb) begin
            model_pixel(int'(x), int'(y), active, exp_col, exp_hit);
        end
        #1;
        n_tests++;
        if ({r, g, b} !== exp_col || hit !== exp_hit) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t rgb=%02h hit=%04b expected rgb=%02h hit=%04b",
                     $time, {r, g, b}, hit, exp_col, exp_hit);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end
    endtask

    task automatic probe(input int px, input int py, input bit act,
                         input logic [7:0] lc, input logic [3:0] lh, input string nm);
        @(negedge clk);
        x = 10'(px);
        y = 9'(py);
        active = act;
        pix_stb = 1'b1;
        @(negedge clk);
        pix_stb = 1'b0;
        check({nm, "_rgb"}, 32'({r, g, b}), 32'(lc));
        check({nm, "_hit"}, 32'(hit), 32'(lh));
    endtask

    task automatic write_rect(input int k, input int px, input int py,
                              input int dxr, input int dyr, input int c);
        @(negedge clk);
        wr_en = 1'b1;
        wr_idx = 2'(k);
        wr_x = 10'(px);
        wr_y = 9'(py);
        wr_dx = 4'(dxr);
        wr_dy = 4'(dyr);
        wr_color = 8'(c);
        @(negedge clk);
        wr_en = 1'b0;
        model_write(k, px, py, dxr, dyr, c);
    endtask

    // Pulses i_frame, optionally re-pulses it at loop iterations e1/e2, and
    // counts the clocks with o_busy high over a fixed window.
    task automatic do_frame(input int e1, input int e2, output int cnt);
        cnt = 0;
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            frame = (i == e1 || i == e2);
            if (busy) cnt++;
            @(negedge clk);
        end
        frame = 1'b0;
    endtask

    int cnt;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_rgb", 32'({r, g, b}), 0);
        check("reset_hit", 32'(hit), 0);
        rst_n = 1'b1;

        probe(121, 41, 1'b1, 8'h1C, 4'b0001, "inside_r0");
        check("inside_r0_g", 32'(g), 7);
        probe(120, 41, 1'b1, 8'h00, 4'b0000, "strict_left");
        probe(250, 150, 1'b1, 8'h1C, 4'b0011, "overlap01");
        probe(250, 150, 1'b0, 8'h00, 4'b0000, "inactive");
        probe(300, 210, 1'b1, 8'hE0, 4'b0110, "overlap12");

        write_rect(3, 478, 280, 3, 0, 8'h1C);
        do_frame(-1, -1, cnt);
        model_frame();
        check("busy_len", 32'(cnt), 5);
        probe(481, 281, 1'b1, 8'h1C, 4'b1000, "r3_right_clamp");
        probe(480, 281, 1'b1, 8'h00, 4'b0000, "r3_left_edge");

        write_rect(2, 1, 10, 4'hE, 0, 8'h03);
        do_frame(-1, -1, cnt);
        model_frame();
        probe(1, 11, 1'b1, 8'h03, 4'b0100, "r2_left_clamp");
        probe(0, 11, 1'b1, 8'h00, 4'b0000, "r2_x0_edge");
        do_frame(-1, -1, cnt);
        model_frame();
        probe(2, 11, 1'b1, 8'h00, 4'b0000, "r2_bounced_edge");
        probe(3, 11, 1'b1, 8'h03, 4'b0100, "r2_bounced_in");

        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_frame(-1, -1, cnt);
            check("pause_busy", 32'(cnt), 0);
        end
        pause = 1'b0;
        probe(2, 11, 1'b1, 8'h00, 4'b0000, "pause_edge");
        probe(3, 11, 1'b1, 8'h03, 4'b0100, "pause_in");

        do_frame(1, 4, cnt);
        model_frame();
        check("busy_len_retrig", 32'(cnt), 5);
        probe(4, 11, 1'b1, 8'h00, 4'b0000, "one_step_edge");
        probe(5, 11, 1'b1, 8'h03, 4'b0100, "one_step_in");

        // Write rect 1 exactly when UPDATE is handling idx 1.
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        wr_en = 1'b1;
        wr_idx = 2'd1;
        wr_x = 10'd400;
        wr_y = 9'd300;
        wr_dx = 4'd1;
        wr_dy = 4'd1;
        wr_color = 8'hE0;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("busy_drop", 32'(busy), 0);
        model_frame();
        model_write(1, 400, 300, 1, 1, 8'hE0);
        probe(401, 301, 1'b1, 8'hE0, 4'b0010, "wr_wins_in");
        probe(400, 301, 1'b1, 8'h00, 4'b0000, "wr_wins_edge");

        // Reset in the middle of an update.
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rgb", 32'({r, g, b}), 0);
        check("midrst_hit", 32'(hit), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        probe(121, 41, 1'b1, 8'h1C, 4'b0001, "post_rst_r0");
        probe(250, 150, 1'b1, 8'h1C, 4'b0011, "post_rst_overlap");

        // Most-negative velocity is clamped on load.
        write_rect(0, 20, 100, 4'h8, 0, 8'h1C);
        do_frame(-1, -1, cnt);
        model_frame();
        probe(13, 101, 1'b1, 8'h00, 4'b0000, "clamp_edge");
        probe(14, 101, 1'b1, 8'h1C, 4'b0001, "clamp_in");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
